// File: rtl/mcu_link_pkg.sv
// Shared definitions for the MCU link: command opcodes, STATUS bit layout
// and the SPI command decoder states.
package mcu_link_pkg;

    localparam logic [7:0] CMD_ID      = 8'h01;
    localparam logic [7:0] CMD_CONFIG  = 8'h02;
    localparam logic [7:0] CMD_LOADING = 8'h06;
    localparam logic [7:0] CMD_DATA    = 8'h07;
    localparam logic [7:0] CMD_STATUS  = 8'h08;
    localparam logic [7:0] CMD_CLEAR   = 8'h09;

    localparam int ST_OVERFLOW = 7;
    localparam int ST_FULL     = 6;
    localparam int ST_EMPTY    = 5;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        PAYLOAD,
        DATA,
        DRAIN
    } dec_state_e;

endpackage

// File: rtl/mcu_link_fifo.sv
// Show-ahead FIFO carrying tagged load bytes; one extra pointer bit tells
// full from empty.
module link_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             wr_en, rd_en;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    assign rd_en    = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign wr_en    = push & (~full | rd_en);
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mcu_link.sv
// SPI-slave link from a host MCU: oversampled mode-0 shifter, command decoder,
// configuration/loading registers and a tagged load-data FIFO.
module mcu_link
    import mcu_link_pkg::*;
#(
    parameter logic [15:0] CORE_ID    = 16'h0001,
    parameter int          CFG_BYTES  = 4,
    parameter int          LOAD_CH    = 2,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   sspi_cs,
    input  logic                   sspi_clk,
    input  logic                   sspi_mosi,
    output logic                   sspi_miso,
    output logic [8*CFG_BYTES-1:0] core_config,
    output logic [LOAD_CH-1:0]     rom_loading,
    output logic [2:0]             rom_ch,
    output logic [7:0]             rom_do,
    output logic                   rom_do_valid,
    input  logic                   rom_do_ready,
    output logic                   overflow
);
    logic [1:0] cs_sync_q, cs_sync_d, sclk_sync_q, sclk_sync_d, mosi_sync_q, mosi_sync_d;
    logic       cs_prev_q, cs_prev_d, sclk_prev_q, sclk_prev_d;
    dec_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_q, rx_d, tx_q, tx_d, cmd_q, cmd_d;
    logic [3:0] pay_cnt_q, pay_cnt_d;
    logic       miso_q, miso_d;
    logic [8*CFG_BYTES-1:0] cfg_sh_q, cfg_sh_d, core_config_q, core_config_d;
    logic [LOAD_CH-1:0]     rom_loading_q, rom_loading_d;
    logic [2:0]  ch_q, ch_d;
    logic [23:0] len_q, len_d;
    logic        push_q, push_d, overflow_q, overflow_d;
    logic [10:0] push_data_q, push_data_d, fifo_dout;
    logic        cs_s, sclk_rise, sclk_fall, cs_fall, byte_done, flush, clr_ovf;
    logic        fifo_full, fifo_empty, pop;
    logic [7:0]  byte_val, status;

    assign cs_s      = cs_sync_q[1];
    assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q[1] & sclk_prev_q;
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign byte_val  = {rx_q[6:0], mosi_sync_q[1]};

    always_comb begin
        status              = '0;
        status[ST_OVERFLOW] = overflow_q;
        status[ST_FULL]     = fifo_full;
        status[ST_EMPTY]    = fifo_empty;
    end

    function automatic logic [7:0] resp_byte(input logic [7:0] cmd, input logic [3:0] idx,
                                             input logic [7:0] st);
        logic [7:0] r;
        r = 8'h00;
        if (cmd == CMD_STATUS) r = st;
        else if (cmd == CMD_ID) begin
            case (idx)
                4'd0:    r = CORE_ID[7:0];
                4'd1:    r = CORE_ID[15:8];
                4'd2:    r = 8'(LOAD_CH);
                4'd3:    r = 8'(FIFO_DEPTH);
                default: r = 8'h00;
            endcase
        end
        return r;
    endfunction

    always_comb begin
        cs_sync_d     = {cs_sync_q[0], sspi_cs};
        sclk_sync_d   = {sclk_sync_q[0], sspi_clk};
        mosi_sync_d   = {mosi_sync_q[0], sspi_mosi};
        cs_prev_d     = cs_s;
        sclk_prev_d   = sclk_sync_q[1];
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_d          = rx_q;
        tx_d          = tx_q;
        cmd_d         = cmd_q;
        pay_cnt_d     = pay_cnt_q;
        miso_d        = miso_q;
        cfg_sh_d      = cfg_sh_q;
        core_config_d = core_config_q;
        rom_loading_d = rom_loading_q;
        ch_d          = ch_q;
        len_d         = len_q;
        push_d        = 1'b0;
        push_data_d   = push_data_q;
        byte_done     = 1'b0;
        flush         = 1'b0;
        clr_ovf       = 1'b0;

        if (cs_s) begin
            // Deselect aborts whatever was in flight; only committed state survives.
            state_d   = IDLE;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
            len_d     = '0;
        end else if (state_q == IDLE) begin
            // Only a fresh cs falling edge starts a transaction, so one cut by reset stays ignored.
            if (cs_fall) begin
                state_d   = CMD;
                bit_cnt_d = '0;
                pay_cnt_d = '0;
                cfg_sh_d  = '0;
                tx_d      = '0;
                miso_d    = 1'b0;
            end
        end else begin
            if (sclk_rise) begin
                rx_d      = byte_val;
                bit_cnt_d = bit_cnt_q + 3'd1;
                byte_done = (bit_cnt_q == 3'd7);
            end
            if (sclk_fall) miso_d = tx_q[3'd7 - bit_cnt_q];
        end

        if (byte_done) begin
            if (state_q == CMD) begin
                cmd_d   = byte_val;
                tx_d    = resp_byte(byte_val, 4'd0, status);
                state_d = (byte_val == CMD_DATA) ? DATA : PAYLOAD;
                if (byte_val == CMD_CLEAR) begin
                    flush   = 1'b1;
                    clr_ovf = 1'b1;
                end
            end else begin
                pay_cnt_d = (pay_cnt_q == 4'hF) ? pay_cnt_q : pay_cnt_q + 4'd1;
                tx_d      = resp_byte(cmd_q, pay_cnt_d, status);
                if (state_q == PAYLOAD && cmd_q == CMD_CONFIG) begin
                    for (int i = 0; i < CFG_BYTES; i++) begin
                        if (pay_cnt_q == 4'(i)) cfg_sh_d[8*i +: 8] = byte_val;
                    end
                    if (pay_cnt_q == 4'(CFG_BYTES - 1)) begin
                        core_config_d = cfg_sh_d;
                        state_d       = DRAIN;
                    end
                end else if (state_q == PAYLOAD && cmd_q == CMD_LOADING) begin
                    for (int i = 0; i < LOAD_CH; i++) begin
                        if (byte_val[3:1] == 3'(i)) rom_loading_d[i] = byte_val[0];
                    end
                    state_d = DRAIN;
                end else if (state_q == DATA) begin
                    case (pay_cnt_q)
                        4'd0: ch_d         = byte_val[2:0];
                        4'd1: len_d[7:0]   = byte_val;
                        4'd2: len_d[15:8]  = byte_val;
                        4'd3: len_d[23:16] = byte_val;
                        default: begin
                            if (len_q != '0) begin
                                push_d      = 1'b1;
                                push_data_d = {ch_q, byte_val};
                                len_d       = len_q - 24'd1;
                            end
                        end
                    endcase
                end
            end
        end

        overflow_d = clr_ovf ? 1'b0 : overflow_q;
        if (push_q && fifo_full && !pop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cs_sync_q     <= '0;
            sclk_sync_q   <= '0;
            mosi_sync_q   <= '0;
            cs_prev_q     <= 1'b0;
            sclk_prev_q   <= 1'b0;
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            rx_q          <= '0;
            tx_q          <= '0;
            cmd_q         <= '0;
            pay_cnt_q     <= '0;
            miso_q        <= 1'b0;
            cfg_sh_q      <= '0;
            core_config_q <= '0;
            rom_loading_q <= '0;
            ch_q          <= '0;
            len_q         <= '0;
            push_q        <= 1'b0;
            push_data_q   <= '0;
            overflow_q    <= 1'b0;
        end else begin
            cs_sync_q     <= cs_sync_d;
            sclk_sync_q   <= sclk_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            cs_prev_q     <= cs_prev_d;
            sclk_prev_q   <= sclk_prev_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_q          <= rx_d;
            tx_q          <= tx_d;
            cmd_q         <= cmd_d;
            pay_cnt_q     <= pay_cnt_d;
            miso_q        <= miso_d;
            cfg_sh_q      <= cfg_sh_d;
            core_config_q <= core_config_d;
            rom_loading_q <= rom_loading_d;
            ch_q          <= ch_d;
            len_q         <= len_d;
            push_q        <= push_d;
            push_data_q   <= push_data_d;
            overflow_q    <= overflow_d;
        end
    end

    assign pop = rom_do_valid & rom_do_ready;

    link_fifo #(.WIDTH(11), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .push      (push_q),
        .push_data (push_data_q),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign sspi_miso    = miso_q;
    assign core_config  = core_config_q;
    assign rom_loading  = rom_loading_q;
    assign overflow     = overflow_q;
    assign rom_do_valid = ~fifo_empty;
    assign rom_ch       = fifo_dout[10:8];
    assign rom_do       = fifo_dout[7:0];

endmodule

// File: tb/tb_mcu_link.sv
// Directed bench for mcu_link: bit-banged SPI master, hand-computed expectations.
module tb_mcu_link;
    logic        clk = 1'b0, resetn = 1'b0;
    logic        sspi_cs = 1'b1, sspi_clk = 1'b0, sspi_mosi = 1'b0, rom_do_ready = 1'b0;
    logic        sspi_miso, rom_do_valid, overflow;
    logic [31:0] core_config;
    logic [1:0]  rom_loading;
    logic [2:0]  rom_ch;
    logic [7:0]  rom_do;

    int n_cmp = 0, n_bad = 0;
    logic [7:0] tq[$];
    logic [7:0] rx[$];

    mcu_link #(.CORE_ID(16'h0002)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .sspi_cs      (sspi_cs),
        .sspi_clk     (sspi_clk),
        .sspi_mosi    (sspi_mosi),
        .sspi_miso    (sspi_miso),
        .core_config  (core_config),
        .rom_loading  (rom_loading),
        .rom_ch       (rom_ch),
        .rom_do       (rom_do),
        .rom_do_valid (rom_do_valid),
        .rom_do_ready (rom_do_ready),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", tag, act, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sspi_mosi = tx[i];
            #80;
            b[i] = sspi_miso;
            sspi_clk = 1'b1;
            #80;
            sspi_clk = 1'b0;
        end
    endtask

    task automatic cs_on();
        rx.delete();
        sspi_cs = 1'b0;
        #100;
    endtask

    task automatic send(input logic [7:0] tx);
        logic [7:0] b;
        spi_byte(tx, b);
        rx.push_back(b);
    endtask

    task automatic cs_off();
        #100;
        sspi_cs = 1'b1;
        #200;
    endtask

    task automatic txn();
        cs_on();
        foreach (tq[i]) send(tq[i]);
        cs_off();
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (4) @(negedge clk);
        chk("rst core_config", core_config, 32'h0);
        chk("rst rom_loading", rom_loading, 2'b00);
        chk("rst overflow", overflow, 1'b0);
        chk("rst valid", rom_do_valid, 1'b0);
        chk("rst rom_do", rom_do, 8'h00);
        chk("rst rom_ch", rom_ch, 3'd0);
        chk("rst miso", sspi_miso, 1'b0);
        resetn = 1'b1;
        repeat (10) @(negedge clk);

        // ID
        tq = {8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        txn();
        chk("id b0", rx[1], 8'h02);
        chk("id b1", rx[2], 8'h00);
        chk("id b2", rx[3], 8'h02);
        chk("id b3", rx[4], 8'h10);
        chk("id b4 pad", rx[5], 8'h00);
        chk("miso idle", sspi_miso, 1'b0);

        // CONFIG, commit only after the last byte
        cs_on();
        send(8'h02); send(8'h78); send(8'h56); send(8'h34);
        #200;
        chk("cfg partial", core_config, 32'h0);
        send(8'h12);
        #200;
        chk("cfg commit", core_config, 32'h12345678);
        cs_off();
        tq = {8'h02, 8'hAA, 8'hBB};
        txn();
        chk("cfg abort", core_config, 32'h12345678);
        tq = {8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        txn();
        chk("cfg extra ignored", core_config, 32'h04030201);

        // LOADING
        tq = {8'h06, 8'h03};
        txn();
        chk("load ch1", rom_loading, 2'b10);
        tq = {8'h06, 8'h0F};
        txn();
        chk("load ch7 ignored", rom_loading, 2'b10);
        tq = {8'h06, 8'h02};
        txn();
        chk("load ch1 clr", rom_loading, 2'b00);

        // DATA len=0 pushes nothing
        tq = {8'h07, 8'h02, 8'h00, 8'h00, 8'h00, 8'h55};
        txn();
        chk("len0 valid", rom_do_valid, 1'b0);

        // DATA with backpressure, trailing byte beyond len
        tq = {8'h07, 8'h01, 8'h03, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        txn();
        repeat (20) @(negedge clk);
        chk("bp valid held", rom_do_valid, 1'b1);
        chk("bp head stable", rom_do, 8'h11);
        @(negedge clk);
        rom_do_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic [7:0] e;
            e = 8'h11 * 8'(k + 1);
            chk("pop valid", rom_do_valid, 1'b1);
            chk("pop data", rom_do, e);
            chk("pop ch", rom_ch, 3'd1);
            @(negedge clk);
        end
        chk("pop drained", rom_do_valid, 1'b0);
        rom_do_ready = 1'b0;

        // Overflow: 18 bytes into a 16-deep FIFO
        tq = {8'h07, 8'h05, 8'h12, 8'h00, 8'h00};
        for (int i = 0; i < 18; i++) tq.push_back(8'(8'h40 + i));
        txn();
        chk("ovf flag", overflow, 1'b1);
        chk("ovf head", rom_do, 8'h40);
        chk("ovf ch", rom_ch, 3'd5);
        tq = {8'h08, 8'h00, 8'h00};
        txn();
        chk("status full", rx[1], 8'hC0);
        chk("status full rep", rx[2], 8'hC0);
        tq = {8'h09};
        txn();
        chk("clear ovf", overflow, 1'b0);
        chk("clear flush", rom_do_valid, 1'b0);
        tq = {8'h08, 8'h00};
        txn();
        chk("status empty", rx[1], 8'h20);

        // Reset in the middle of a DATA transfer
        tq = {8'h06, 8'h01};
        txn();
        chk("pre-rst loading", rom_loading, 2'b01);
        cs_on();
        send(8'h07); send(8'h03); send(8'h04); send(8'h00); send(8'h00); send(8'hAA);
        repeat (20) @(negedge clk);
        chk("pre-rst push", rom_do, 8'hAA);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid-rst valid", rom_do_valid, 1'b0);
        chk("mid-rst rom_do", rom_do, 8'h00);
        chk("mid-rst rom_ch", rom_ch, 3'd0);
        chk("mid-rst loading", rom_loading, 2'b00);
        chk("mid-rst config", core_config, 32'h0);
        chk("mid-rst ovf", overflow, 1'b0);
        chk("mid-rst miso", sspi_miso, 1'b0);
        resetn = 1'b1;
        send(8'hBB); send(8'hCC); send(8'hDD);
        cs_off();
        chk("post-rst no push", rom_do_valid, 1'b0);
        tq = {8'h07, 8'h02, 8'h01, 8'h00, 8'h00, 8'h77};
        txn();
        chk("recover data", rom_do, 8'h77);
        chk("recover ch", rom_ch, 3'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
